// File: rtl/sram_dual_lane_if.sv
// Port bundle for sram_dual_lane: clear/busy control plus the read and write ports.
interface sram_dual_lane_if #(
  parameter int unsigned SRAM_DEPTH_BIT = 6,
  parameter int unsigned SRAM_WIDTH     = 28,
  parameter int unsigned NUM_LANE       = 4
);
  logic                      clear;
  logic                      busy;
  logic                      read_en;
  logic [SRAM_DEPTH_BIT-1:0] addr_r;
  logic                      write_en;
  logic [SRAM_DEPTH_BIT-1:0] addr_w;
  logic [NUM_LANE-1:0]       wmask;
  logic [SRAM_WIDTH-1:0]     data_in;
  logic [SRAM_WIDTH-1:0]     data_out;
  logic                      data_valid;

  modport master (
    output clear, read_en, addr_r, write_en, addr_w, wmask, data_in,
    input  busy, data_out, data_valid
  );

  modport slave (
    input  clear, read_en, addr_r, write_en, addr_w, wmask, data_in,
    output busy, data_out, data_valid
  );
endinterface

// File: rtl/sram_dual_lane.sv
// 1R1W SRAM with per-lane write mask, write-first collision forwarding and a clear engine.
// Optional SRAM_DUAL_LANE_OUTREG_EN adds an output register stage (read latency 2).
module sram_dual_lane #(
  parameter int unsigned SRAM_DEPTH_BIT = 6,
  parameter int unsigned SRAM_WIDTH     = 28,
  parameter int unsigned NUM_LANE       = 4
) (
  input logic             clk,
  input logic             rst_n,
  sram_dual_lane_if.slave bus
);
  localparam int unsigned SRAM_DEPTH = 1 << SRAM_DEPTH_BIT;
  localparam int unsigned LANE_W     = SRAM_WIDTH / NUM_LANE;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [SRAM_DEPTH_BIT-1:0] ptr;
  logic [SRAM_DEPTH_BIT-1:0] ptr_next;
  logic                      busy_next;
  logic                      rd_fire_c;
  logic                      wr_fire_c;
  logic [SRAM_WIDTH-1:0]     wbits_c;
  logic [SRAM_WIDTH-1:0]     rd_word_c;
  logic [SRAM_WIDTH-1:0]     mem [SRAM_DEPTH];

  // State, clear pointer and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      ptr      <= '0;
      bus.busy <= 1'b1;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      bus.busy <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    busy_next  = 1'b0;
    rd_fire_c  = 1'b0;
    wr_fire_c  = 1'b0;
    unique case (state)
      CLEAR: begin
        busy_next = 1'b1;
        ptr_next  = ptr + SRAM_DEPTH_BIT'(1);
        if (ptr == SRAM_DEPTH_BIT'(SRAM_DEPTH - 1)) begin
          state_next = IDLE;
          ptr_next   = '0;
          busy_next  = 1'b0;
        end
      end
      IDLE: begin
        rd_fire_c = bus.read_en;
        wr_fire_c = bus.write_en;
        if (bus.clear) begin
          state_next = CLEAR;
          ptr_next   = '0;
          busy_next  = 1'b1;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // Expand lane enables to a bit mask
  always_comb begin
    wbits_c = '0;
    for (int i = 0; i < int'(NUM_LANE); i++) begin
      wbits_c[i*LANE_W +: LANE_W] = {LANE_W{bus.wmask[i]}};
    end
  end

  // Write-first: colliding lanes return the incoming data
  always_comb begin
    rd_word_c = mem[bus.addr_r];
    if (wr_fire_c && (bus.addr_w == bus.addr_r)) begin
      rd_word_c = (mem[bus.addr_r] & ~wbits_c) | (bus.data_in & wbits_c);
    end
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_fire_c) begin
      mem[bus.addr_w] <= (mem[bus.addr_w] & ~wbits_c) | (bus.data_in & wbits_c);
    end
  end

`ifdef SRAM_DUAL_LANE_OUTREG_EN
  logic [SRAM_WIDTH-1:0] data_s1;
  logic                  valid_s1;

  // Data captured at issue, then presented one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_s1        <= '0;
      valid_s1       <= 1'b0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
    end else begin
      valid_s1       <= rd_fire_c;
      bus.data_valid <= valid_s1;
      if (rd_fire_c) begin
        data_s1 <= rd_word_c;
      end
      if (valid_s1) begin
        bus.data_out <= data_s1;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
    end else begin
      bus.data_valid <= rd_fire_c;
      if (rd_fire_c) begin
        bus.data_out <= rd_word_c;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sram_dual_lane.sv
// Scoreboard bench for sram_dual_lane: directed scenarios followed by random traffic.
module tb_sram_dual_lane;
  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 28;
  localparam int unsigned NL    = 4;
  localparam int unsigned LW    = DW / NL;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef SRAM_DUAL_LANE_OUTREG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   at;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  int unsigned   cyc = 0;
  int            vectors = 0;
  int            errors = 0;
  exp_t          sbq[$];
  logic [DW-1:0] model [DEPTH];
  int            clear_left = 0;
  logic [DW-1:0] last_data = '0;

  sram_dual_lane_if #(.SRAM_DEPTH_BIT(AW), .SRAM_WIDTH(DW), .NUM_LANE(NL)) bus ();

  sram_dual_lane #(.SRAM_DEPTH_BIT(AW), .SRAM_WIDTH(DW), .NUM_LANE(NL)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] lane_bits(input logic [NL-1:0] wm);
    logic [DW-1:0] b = '0;
    for (int i = 0; i < int'(NL); i++) begin
      if (wm[i]) b[i*LW +: LW] = '1;
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances by the same edge
  task automatic step(input bit rd, input logic [AW-1:0] ar, input bit wr,
                      input logic [AW-1:0] aw, input logic [NL-1:0] wm,
                      input logic [DW-1:0] din, input bit clr);
    logic [DW-1:0] bits;
    logic [DW-1:0] e;
    @(negedge clk);
    check("busy", 64'(bus.busy), 64'(clear_left > 0));
    bus.read_en  = rd;
    bus.addr_r   = ar;
    bus.write_en = wr;
    bus.addr_w   = aw;
    bus.wmask    = wm;
    bus.data_in  = din;
    bus.clear    = clr;
    if (clear_left == 0) begin
      bits = lane_bits(wm);
      if (rd) begin
        e = model[ar];
        if (wr && aw == ar) e = (e & ~bits) | (din & bits);
        sbq.push_back('{e, cyc + 1});
      end
      if (wr) model[aw] = (model[aw] & ~bits) | (din & bits);
      if (clr) begin
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        clear_left = DEPTH;
      end
    end else begin
      clear_left--;
    end
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b1, a, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NL-1:0] wm, input logic [DW-1:0] d);
    step(1'b0, '0, 1'b1, a, wm, d, 1'b0);
  endtask

  // Reset, checked while held, released just after a rising edge
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.read_en = 1'b0;
    bus.write_en = 1'b0;
    bus.clear = 1'b0;
    sbq.delete();
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd1);
    check("rst_valid", 64'(bus.data_valid), 64'd0);
    check("rst_data", 64'(bus.data_out), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    clear_left = DEPTH;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        last_data = '0;
        continue;
      end
      if (bus.data_valid) begin
        if (sbq.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL spurious_valid @cyc %0d: got data_valid 1, expected 0", cyc);
        end else begin
          e = sbq.pop_front();
          check("rd_data", 64'(bus.data_out), 64'(e.data));
          check("rd_latency", 64'(cyc), 64'(e.at + LAT - 1));
        end
        last_data = bus.data_out;
      end else begin
        check("data_hold", 64'(bus.data_out), 64'(last_data));
        if (sbq.size() > 0 && cyc >= sbq[0].at + LAT - 1) begin
          e = sbq.pop_front();
          vectors++;
          errors++;
          $display("FAIL missing_valid @cyc %0d: got data_valid 0, expected 1 (data %h)", cyc, e.data);
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] ar;
    logic [AW-1:0] aw;
    bus.clear = 1'b0;
    bus.read_en = 1'b0;
    bus.addr_r = '0;
    bus.write_en = 1'b0;
    bus.addr_w = '0;
    bus.wmask = '0;
    bus.data_in = '0;

    do_reset();
    // Reset again with the clear pointer at 30; a full clear must follow
    repeat (30) idle();
    do_reset();
    while (clear_left > 0) idle();
    idle();
    rd(AW'(63));

    wr(AW'(5), 4'b1111, 28'hABCDEF1);
    wr(AW'(5), 4'b0001, 28'h0000000);
    rd(AW'(5));
    wr(AW'(7), 4'b0000, 28'h5555555);
    rd(AW'(7));

    // Write-first collision with partial mask
    wr(AW'(9), 4'b1111, 28'hFFFFFFF);
    step(1'b1, AW'(9), 1'b1, AW'(9), 4'b1010, 28'h1234567, 1'b0);
    rd(AW'(9));

    // Clear pulsed together with a write; reads during the clear are ignored
    step(1'b1, AW'(3), 1'b1, AW'(3), 4'b1111, 28'h7654321, 1'b1);
    while (clear_left > 0) step(1'b1, AW'($urandom_range(0, 63)), 1'b1, AW'(3), 4'b1111, 28'h1111111, 1'b0);
    rd(AW'(3));
    rd(AW'(9));

    // Back-to-back reads
    wr(AW'(1), 4'b1111, 28'h0000111);
    wr(AW'(2), 4'b1111, 28'h0000222);
    wr(AW'(3), 4'b1111, 28'h0000333);
    rd(AW'(1));
    rd(AW'(2));
    rd(AW'(3));
    idle();

    for (int n = 0; n < 2000; n++) begin
      ar = AW'($urandom_range(0, 63));
      aw = ($urandom_range(0, 3) == 0) ? ar : AW'($urandom_range(0, 63));
      step(($urandom_range(0, 2) != 0), ar, ($urandom_range(0, 1) != 0), aw,
           NL'($urandom_range(0, 15)), DW'($urandom()), ($urandom_range(0, 299) == 0));
    end

    while (clear_left > 0) idle();
    repeat (4) idle();
    check("drain", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
